video_timing_gen: RTL
=====================

# video_timing_gen

Raster timing generator that produces the `blank`/`hsync`/`vsync` stream driving the 5x7 font engines and overlays, plus pixel coordinates and frame markers. It walks horizontal and vertical position counters through active, front-porch, sync and back-porch regions on each pixel clock enable. It sits between the clock/reset block and the font engine / display output stage.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch, pixels
- `H_SYNC`, 96, hsync width, pixels
- `H_BP`, 48, horizontal back porch, pixels
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch, lines
- `V_SYNC`, 2, vsync width, lines
- `V_BP`, 33, vertical back porch, lines
- `HS_POL`, 0, pin polarity of `hsync_pin` (0 = active-low)
- `VS_POL`, 0, pin polarity of `vsync_pin` (0 = active-low)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `ce`  in  1  pixel clock enable; state advances only when high
- `blank`  out  1  high outside the active region (horizontal or vertical)
- `hsync`  out  1  active-high internal hsync
- `vsync`  out  1  active-high internal vsync
- `hsync_pin`  out  1  `hsync` XOR `~HS_POL`
- `vsync_pin`  out  1  `vsync` XOR `~VS_POL`
- `pix_x`  out  12  horizontal counter, 0..H_TOTAL-1
- `pix_y`  out  12  vertical counter, 0..V_TOTAL-1
- `sof`  out  1  one-`ce` pulse at position (0,0)
- `eol`  out  1  high at pix_x == H_ACTIVE-1 on active lines
- `frame_cnt`  out  8  frames started since reset, wraps 255->0

Clock `clk`, reset `reset` (synchronous, active-high).

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Both must be ≤ 4096; elaboration fails otherwise, or if any parameter is 0.
- Region order per axis: active [0, ACTIVE), front porch, sync [ACTIVE+FP, ACTIVE+FP+SYNC), back porch.
- On `ce`: pix_x increments; at H_TOTAL-1 it wraps to 0 and pix_y increments; pix_y wraps from V_TOTAL-1 to 0.
- `blank` = (pix_x ≥ H_ACTIVE) | (pix_y ≥ V_ACTIVE). Stays high through the entire vertical blanking interval, so consumers counting `blank` rising edges see exactly V_ACTIVE edges per frame.
- `hsync` is decoded from pix_x on every line, including vblank lines.
- `vsync` is decoded from pix_y only, so it changes at pix_x == 0.
- `vsync` always falls inside the vblank period, after the last active line's blank rise. A font engine clearing its line count on `vsync` therefore starts each frame at line 0.
- `sof`: pix_x == 0 && pix_y == 0, gated by `ce`.
- `frame_cnt` increments on the same `ce` edge that enters (0,0).
- `eol` is position-decoded and is not gated by `ce`.

## Timing
- All outputs are flops loaded from next-state counter values. Each output describes the current pix_x/pix_y with zero lag; no output is combinational from `ce`.
- `ce` low: all outputs hold, except `sof`, which drops to 0.
- Reset value: pix_x = H_TOTAL-1, pix_y = V_TOTAL-1, blank = 1, hsync = 0, vsync = 0, sof = 0, eol = 0, frame_cnt = 0.
  - `hsync_pin` / `vsync_pin` are at their inactive levels.
  - H_BP ≥ 1 and V_BP ≥ 1 guarantee the syncs are inactive at that position.
- The first `ce` after reset goes to (0,0): blank = 0, sof = 1, frame_cnt = 1.
- Reset mid-frame overrides `ce` and returns to the reset position on the next clock edge.
- Line wrap and frame wrap on the same `ce` both resolve in one cycle.

## Structure
- Package `video_timing_pkg`:
  - `localparam` sets for 640x480@60 and 800x600@60;
  - typedef `timing_t` struct {active, fp, sync, bp} of 12-bit fields;
  - function `total(timing_t)`.
- Sub-module `timing_axis`, instantiated twice (h, v):
  - inputs: clk, reset, step, timing_t parameter;
  - outputs: count, wrap, active, sync (all registered);
  - `wrap` of the h instance drives `step` of the v instance (gated by `ce`).

## Test plan
Small timing: H 8/2/3/1 (H_TOTAL = 14), V 4/1/2/1 (V_TOTAL = 8).
- Reset, `ce` held high:
  - before the first `ce`: pix = (13,7), blank = 1, sof = 0, frame_cnt = 0;
  - first `ce`: (0,0), sof = 1, blank = 0, frame_cnt = 1.
- Line 0: blank low for pix_x 0..7, high for 8..13; hsync high for pix_x 10..12; eol high at pix_x = 7 only.
- Frame: vsync high for all 28 pixels of lines 5..6 and low on lines 0..4 and 7; exactly 4 blank rising edges per 112-cycle frame.
- `ce` toggling 1-0-1: outputs hold during `ce` = 0; sof lasts one `ce`-qualified cycle; positions identical to the continuous run.
- Reset asserted at (9,2) with `ce` = 1: next cycle at reset values; hsync_pin and vsync_pin both 1 (HS_POL = VS_POL = 0).
- Run 256 frames: frame_cnt wraps 255 -> 0 on the 256th sof, and sof recurs every 112 `ce`.

Source files
------------

// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - raster timing sets and helpers for video_timing_gen
package video_timing_pkg;

  // One axis of a raster: region lengths in pixels (h) or lines (v)
  typedef struct packed {
    logic [11:0] active;
    logic [11:0] fp;
    logic [11:0] sync;
    logic [11:0] bp;
  } timing_t;

  localparam timing_t H_640X480 = '{active: 12'd640, fp: 12'd16, sync: 12'd96,  bp: 12'd48};
  localparam timing_t V_640X480 = '{active: 12'd480, fp: 12'd10, sync: 12'd2,   bp: 12'd33};
  localparam timing_t H_800X600 = '{active: 12'd800, fp: 12'd40, sync: 12'd128, bp: 12'd88};
  localparam timing_t V_800X600 = '{active: 12'd600, fp: 12'd1,  sync: 12'd4,   bp: 12'd23};

  // Total period of one axis; 13 bits so a full 4096 period is representable
  function automatic logic [12:0] total(timing_t t);
    return 13'(t.active) + 13'(t.fp) + 13'(t.sync) + 13'(t.bp);
  endfunction

endpackage

// File: rtl/timing_axis.sv
// rtl/timing_axis.sv - one raster axis counter with registered region decodes
module timing_axis
  import video_timing_pkg::*;
#(
  parameter timing_t P = H_640X480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  output logic [11:0] count,
  output logic        wrap,
  output logic        active,
  output logic        sync
);

  localparam logic [12:0] TOT     = total(P);
  localparam logic [11:0] LAST    = 12'(TOT - 13'd1);
  localparam logic [11:0] SYNC_LO = 12'(13'(P.active) + 13'(P.fp));
  localparam logic [12:0] SYNC_HI = 13'(P.active) + 13'(P.fp) + 13'(P.sync);

  logic [11:0] w_next;

  // Next position along the axis, wrapping after the last back-porch slot
  always_comb begin
    w_next = (count == LAST) ? 12'd0 : count + 12'd1;
  end

  // Decodes are computed from the next count so they line up with it, zero lag
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= LAST;
      wrap   <= 1'b1;
      active <= 1'b0;
      sync   <= 1'b0;
    end else if (step) begin
      count  <= w_next;
      wrap   <= (w_next == LAST);
      active <= (w_next < P.active);
      sync   <= (w_next >= SYNC_LO) && ({1'b0, w_next} < SYNC_HI);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator: syncs, blank, coordinates, frame markers
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  output logic        blank,
  output logic        hsync,
  output logic        vsync,
  output logic        hsync_pin,
  output logic        vsync_pin,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        sof,
  output logic        eol,
  output logic [7:0]  frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 4096 || V_TOTAL > 4096 ||
      H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
      V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_params
    $error("video_timing_gen: region lengths must be nonzero and totals at most 4096");
  end

  localparam timing_t H_TIM = '{active: 12'(H_ACTIVE), fp: 12'(H_FP), sync: 12'(H_SYNC), bp: 12'(H_BP)};
  localparam timing_t V_TIM = '{active: 12'(V_ACTIVE), fp: 12'(V_FP), sync: 12'(V_SYNC), bp: 12'(V_BP)};

  localparam logic [11:0] H_LAST_ACT = 12'(H_ACTIVE - 1);
  localparam logic [11:0] V_LAST_ACT = 12'(V_ACTIVE - 1);
  localparam logic [11:0] H_PRE_EOL  = 12'(H_ACTIVE - 2);

  logic w_h_wrap, w_h_active;
  logic w_v_wrap, w_v_active;
  logic w_v_step;
  logic w_nh_act, w_nv_act, w_nh_eol;

  logic       r_blank;
  logic       r_sof;
  logic       r_eol;
  logic [7:0] r_frame_cnt;

  timing_axis #(.P(H_TIM)) u_h_axis (
    .clk    (clk),
    .reset  (reset),
    .step   (ce),
    .count  (pix_x),
    .wrap   (w_h_wrap),
    .active (w_h_active),
    .sync   (hsync)
  );

  timing_axis #(.P(V_TIM)) u_v_axis (
    .clk    (clk),
    .reset  (reset),
    .step   (w_v_step),
    .count  (pix_y),
    .wrap   (w_v_wrap),
    .active (w_v_active),
    .sync   (vsync)
  );

  // Look-ahead of the region flags at the position the next ce moves to
  always_comb begin
    w_v_step = ce & w_h_wrap;
    w_nh_act = w_h_wrap | (w_h_active & (pix_x != H_LAST_ACT));
    w_nv_act = w_v_step ? (w_v_wrap | (w_v_active & (pix_y != V_LAST_ACT))) : w_v_active;
    w_nh_eol = (H_ACTIVE == 1) ? w_h_wrap : (pix_x == H_PRE_EOL);
  end

  // Position-derived outputs load with the counters; sof is a single ce-wide pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blank     <= 1'b1;
      r_sof       <= 1'b0;
      r_eol       <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else if (ce) begin
      r_blank <= ~(w_nh_act & w_nv_act);
      r_eol   <= w_nh_eol & w_nv_act;
      r_sof   <= w_h_wrap & w_v_wrap;
      if (w_h_wrap & w_v_wrap) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end else begin
      r_sof <= 1'b0;
    end
  end

  assign blank     = r_blank;
  assign sof       = r_sof;
  assign eol       = r_eol;
  assign frame_cnt = r_frame_cnt;
  assign hsync_pin = hsync ^ ~HS_POL;
  assign vsync_pin = vsync ^ ~VS_POL;

endmodule
